// File: rtl/maze_memory_pkg.sv
// Shared constants and types for the maze bitmap memory.
// Used by maze_memory, maze_row_bank and maze_memory_if.
package maze_pkg;

  localparam int MAZE_DIM = 16;
  localparam int MAZE_AW  = 4;
  localparam int VISIT_W  = 9;

  localparam logic CELL_WALL = 1'b1;
  localparam logic CELL_FREE = 1'b0;

  localparam logic [VISIT_W-1:0] VISIT_MAX = 9'd256;

  typedef logic [MAZE_DIM-1:0] maze_row_t;

endpackage

// File: rtl/maze_memory_if.sv
// Solver/host-to-maze memory interface.
// The master side is the solver plus row-load host; the slave side is maze_memory.
interface maze_memory_if;
  import maze_pkg::*;

  logic [MAZE_AW-1:0] x;
  logic [MAZE_AW-1:0] y;
  logic               rd;
  logic               wr;
  logic               din;
  logic               rst_map;
  logic               dout;
  logic               load_we;
  logic [MAZE_AW-1:0] load_row;
  maze_row_t          load_data;
  logic               map_ready;
  logic [VISIT_W-1:0] visit_cnt;

  modport master (
    output x, y, rd, wr, din, rst_map, load_we, load_row, load_data,
    input  dout, map_ready, visit_cnt
  );

  modport slave (
    input  x, y, rd, wr, din, rst_map, load_we, load_row, load_data,
    output dout, map_ready, visit_cnt
  );

endinterface

// File: rtl/maze_memory_row_bank.sv
// One maze row: working bits plus the shadow copy used to restore the original walls.
// A host load takes priority over a restore, and a restore takes priority over a solver write.
module maze_row_bank
  import maze_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic               restore,
  input  logic               wr_en,
  input  logic [MAZE_AW-1:0] col,
  input  logic               din,
  input  maze_row_t          load_data,
  output maze_row_t          work
);

  maze_row_t shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      shadow <= '0;
    end else if (load_en) begin
      work   <= load_data;
      shadow <= load_data;
    end else if (restore) begin
      work   <= shadow;
    end else if (wr_en) begin
      work[col] <= din;
    end
  end

endmodule

// File: rtl/maze_memory.sv
// Maze bitmap memory: DIM row banks, a registered read port, a loaded-row mask and map_ready.
// Optional feature: define MAZE_VISIT_COUNT_EN to build the saturating visit_cnt counter.
module maze_memory
  import maze_pkg::*;
(
  input logic          clk,
  input logic          rst,
  maze_memory_if.slave bus
);

  maze_row_t          work [MAZE_DIM];
  logic               cur_bit;
  logic               dout_q;
  logic [MAZE_DIM-1:0] loaded;
  logic [MAZE_DIM-1:0] loaded_next;
  logic               ready_q;

  for (genvar r = 0; r < MAZE_DIM; r++) begin : g_row
    maze_row_bank u_row (
      .clk       (clk),
      .rst       (rst),
      .load_en   (bus.load_we && (bus.load_row == MAZE_AW'(r))),
      .restore   (bus.rst_map),
      .wr_en     (bus.wr && (bus.y == MAZE_AW'(r))),
      .col       (bus.x),
      .din       (bus.din),
      .load_data (bus.load_data),
      .work      (work[r])
    );
  end

  assign cur_bit = work[bus.y][bus.x];

  // Reads see pre-edge contents, so rd alongside wr/load/rst_map returns the old bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= CELL_FREE;
    end else if (bus.rd) begin
      dout_q <= cur_bit;
    end
  end

  always_comb begin
    loaded_next = loaded;
    if (bus.load_we) begin
      loaded_next[bus.load_row] = 1'b1;
    end
  end

  // map_ready is registered from the next mask so it rises on the edge of the final row load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded  <= '0;
      ready_q <= 1'b0;
    end else begin
      loaded  <= loaded_next;
      ready_q <= &loaded_next;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.map_ready = ready_q;

`ifdef MAZE_VISIT_COUNT_EN
  logic               visit_hit;
  logic [VISIT_W-1:0] visit_q;

  assign visit_hit = bus.wr && (bus.din == CELL_WALL) && (cur_bit == CELL_FREE) &&
                     !bus.rst_map && !(bus.load_we && (bus.load_row == bus.y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      visit_q <= '0;
    end else if (bus.rst_map) begin
      visit_q <= '0;
    end else if (visit_hit && (visit_q != VISIT_MAX)) begin
      visit_q <= visit_q + 1'b1;
    end
  end

  assign bus.visit_cnt = visit_q;
`else
  assign bus.visit_cnt = '0;
`endif

endmodule

// File: tb/tb_maze_memory.sv
// Self-checking bench for maze_memory: flat-array reference model compared every cycle,
// plus directed literal checks. Honors MAZE_VISIT_COUNT_EN for the expected visit count.
module tb_maze_memory;
  import maze_pkg::*;

  logic clk;
  logic rst;
  maze_memory_if bus ();

  maze_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 0;

  // Reference model: the maze as a plain 2-D array updated once per clock edge.
  logic [15:0] m_work   [16];
  logic [15:0] m_shadow [16];
  logic [15:0] m_old    [16];
  logic [15:0] m_loaded;
  logic        m_dout;
  int          m_cnt;
  logic        m_hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_work[i]   = '0;
        m_shadow[i] = '0;
      end
      m_loaded = '0;
      m_dout   = 1'b0;
      m_cnt    = 0;
    end else begin
      m_old = m_work;
      if (bus.rd) m_dout = m_old[bus.y][bus.x];
      m_hit = bus.wr && bus.din && !m_old[bus.y][bus.x] && !bus.rst_map &&
              !(bus.load_we && bus.load_row == bus.y);
      if (bus.rst_map) m_work = m_shadow;
      else if (bus.wr) m_work[bus.y][bus.x] = bus.din;
      if (bus.load_we) begin
        m_work[bus.load_row]   = bus.load_data;
        m_shadow[bus.load_row] = bus.load_data;
        m_loaded[bus.load_row] = 1'b1;
      end
      if (bus.rst_map) m_cnt = 0;
      else if (m_hit && m_cnt < 256) m_cnt = m_cnt + 1;
    end
  end

  function automatic int expCnt(int v);
`ifdef MAZE_VISIT_COUNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      checkOutput("model_dout", int'(bus.dout), int'(m_dout));
      checkOutput("model_map_ready", int'(bus.map_ready), int'(&m_loaded));
      checkOutput("model_visit_cnt", int'(bus.visit_cnt), expCnt(m_cnt));
    end
  end

  task automatic setIdle();
    bus.x = '0; bus.y = '0; bus.rd = 0; bus.wr = 0; bus.din = 0;
    bus.rst_map = 0; bus.load_we = 0; bus.load_row = '0; bus.load_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one cycle of strobes, then returns to idle just after the falling edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic din,
                               input int x, input int y, input logic rmap,
                               input logic lwe, input int lrow, input logic [15:0] ldata);
    bus.rd = rd; bus.wr = wr; bus.din = din;
    bus.x = MAZE_AW'(x); bus.y = MAZE_AW'(y);
    bus.rst_map = rmap; bus.load_we = lwe;
    bus.load_row = MAZE_AW'(lrow); bus.load_data = ldata;
    tick();
    setIdle();
  endtask

  task automatic readCell(int x, int y);
    applyStimulus(1, 0, 0, x, y, 0, 0, 0, 16'h0);
  endtask

  task automatic writeCell(int x, int y, logic d);
    applyStimulus(0, 1, d, x, y, 0, 0, 0, 16'h0);
  endtask

  task automatic loadRow(int r, logic [15:0] d);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, r, d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    setIdle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_on = 1;
    tick();
    checkOutput("reset_dout", int'(bus.dout), 0);
    checkOutput("reset_map_ready", int'(bus.map_ready), 0);
    checkOutput("reset_visit_cnt", int'(bus.visit_cnt), 0);

    for (int r = 0; r < 16; r++) begin
      if (r == 15) checkOutput("t1_ready_before_last", int'(bus.map_ready), 0);
      loadRow(r, (r == 0) ? 16'h0001 : 16'hFFFF);
    end
    checkOutput("t1_ready_after_last", int'(bus.map_ready), 1);
    readCell(0, 0);
    checkOutput("t1_rd_0_0", int'(bus.dout), 1);
    readCell(1, 0);
    checkOutput("t1_rd_1_0", int'(bus.dout), 0);
    tick();
    checkOutput("t1_dout_hold", int'(bus.dout), 0);

    applyStimulus(1, 1, 1, 3, 0, 0, 0, 0, 16'h0);
    checkOutput("t2_rd_wr_old", int'(bus.dout), 0);
    readCell(3, 0);
    checkOutput("t2_rd_new", int'(bus.dout), 1);

    for (int x = 4; x < 8; x++) writeCell(x, 0, 1);
    checkOutput("t3_cnt_five", int'(bus.visit_cnt), expCnt(5));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
    checkOutput("t3_cnt_cleared", int'(bus.visit_cnt), 0);
    for (int x = 3; x < 8; x++) begin
      readCell(x, 0);
      checkOutput("t3_restored_free", int'(bus.dout), 0);
    end
    readCell(0, 0);
    checkOutput("t3_wall_0_0", int'(bus.dout), 1);
    readCell(9, 7);
    checkOutput("t3_wall_9_7", int'(bus.dout), 1);

    applyStimulus(0, 1, 1, 4, 2, 0, 1, 2, 16'h0000);
    readCell(4, 2);
    checkOutput("t4_load_wins", int'(bus.dout), 0);
    checkOutput("t4_load_no_count", int'(bus.visit_cnt), 0);
    applyStimulus(0, 1, 1, 5, 0, 1, 0, 0, 16'h0);
    readCell(5, 0);
    checkOutput("t4_restore_wins_free", int'(bus.dout), 0);
    applyStimulus(0, 1, 0, 5, 1, 1, 0, 0, 16'h0);
    readCell(5, 1);
    checkOutput("t4_restore_wins_wall", int'(bus.dout), 1);

    writeCell(1, 0, 1);
    writeCell(2, 0, 1);
    readCell(1, 0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_dout", int'(bus.dout), 0);
    checkOutput("t5_map_ready", int'(bus.map_ready), 0);
    checkOutput("t5_visit_cnt", int'(bus.visit_cnt), 0);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) readCell(x, y);
    readCell(0, 0);
    checkOutput("t5_cell_0_0", int'(bus.dout), 0);

    for (int r = 0; r < 16; r++) loadRow(r, 16'h0000);
    checkOutput("t6_ready", int'(bus.map_ready), 1);
    writeCell(0, 0, 1);
    checkOutput("t6_first", int'(bus.visit_cnt), expCnt(1));
    writeCell(0, 0, 1);
    checkOutput("t6_already_set", int'(bus.visit_cnt), expCnt(1));
    for (int i = 1; i < 256; i++) writeCell(i % 16, i / 16, 1);
    checkOutput("t6_full", int'(bus.visit_cnt), expCnt(256));
    for (int r = 0; r < 3; r++) begin
      loadRow(r, 16'h0000);
      for (int x = 0; x < ((r == 2) ? 12 : 16); x++) writeCell(x, r, 1);
    end
    checkOutput("t6_saturated", int'(bus.visit_cnt), expCnt(256));
    readCell(11, 2);
    checkOutput("t6_rd_marked", int'(bus.dout), 1);
    readCell(12, 2);
    checkOutput("t6_rd_unmarked", int'(bus.dout), 0);

    cmp_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
